axi_rr_arbiter: RTL and testbench
=================================

Name: axi_rr_arbiter

Overview:
- N-to-1 AXI4 arbiter between CPU-side masters (IFU, LSU, DMA, ...) and the single memory-side AXI master port.
- Independent read and write arbiters, round-robin fairness, burst-aware grant hold.
- Master index driven on AR/AW ID.
- Successor to the fixed 2-port arbiter: adds parametrised master count, rotating priority, and full resp/last/id return paths.

Parameters:
- NUM_MASTERS, 2, number of upstream masters; 2..8.
- DATA_WIDTH, 64, AXI data width.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 4, AXI ID width; must satisfy 2**ID_WIDTH >= NUM_MASTERS.

Ports:
- Vectors are flattened; master i occupies slice [i*W +: W]. N = NUM_MASTERS.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_ar_valid in N; s_ar_ready out N; s_ar_addr in N*ADDR_WIDTH; s_ar_len in N*8; s_ar_size in N*3; s_ar_burst in N*2
- s_r_valid out N; s_r_ready in N; s_r_data out DATA_WIDTH (shared bus); s_r_resp out 2; s_r_last out 1
- s_aw_valid in N; s_aw_ready out N; s_aw_addr in N*ADDR_WIDTH; s_aw_len in N*8; s_aw_size in N*3; s_aw_burst in N*2
- s_w_valid in N; s_w_ready out N; s_w_data in N*DATA_WIDTH; s_w_strb in N*DATA_WIDTH/8; s_w_last in N
- s_b_valid out N; s_b_ready in N; s_b_resp out 2
- m_ar_*, m_r_*, m_aw_*, m_w_*, m_b_*: one standard AXI4 master port; id/addr/len/size/burst/data/strb/last/resp widths per parameters.

Behaviour:
- Read and write paths are identical, independent FSMs.
- Read FSM states:
  - R_IDLE: no grant.
  - R_ADDR: AR forwarded from the granted master.
  - R_DATA: R beats routed to the granted master.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
- Arbitration, in IDLE:
  - If any valid is set, choose the first requester scanning from rr_ptr upward, modulo N.
  - Register the grant index; move to ADDR next cycle.
  - Latency: valid sampled in cycle t; m_*_valid asserted in cycle t+1 at the earliest.
- ADDR phase:
  - m_ar_valid = s_ar_valid[g]; s_ar_ready[g] = m_ar_ready; all other ready bits are 0.
  - m_ar_id = g zero-extended to ID_WIDTH.
  - On handshake, go to R_DATA.
- R_DATA phase:
  - s_r_valid[g] = m_r_valid; m_r_ready = s_r_ready[g].
  - data, resp and last are broadcast; only valid[g] may be 1.
  - On m_r_valid & m_r_ready & m_r_last: go to R_IDLE and set rr_ptr = (g+1) mod N.
- Write path:
  - AW handshake goes to W_DATA.
  - W beats are muxed from g; the beat with valid & ready & last goes to W_RESP.
  - b_valid & b_ready goes to W_IDLE; rr_ptr advances the same way.
  - W data before the AW handshake is not accepted (s_w_ready = 0 in W_ADDR).
- Outputs in IDLE, all 0: every s_*_ready and s_*_valid, every m_*_valid, m_r_ready, m_b_ready.
- Grant hold: the grant does not change until the transaction completes, even if the granted master's valid drops (protocol violation, tolerated). Other requesters wait.
- len=0 single beat: R_DATA exits on the first beat; r_last must be set by the slave.
- Simultaneous read and write from the same master: serviced concurrently on separate FSMs.
- Reset, including mid-burst:
  - FSMs return to IDLE, rr_ptr = 0, all outputs = 0 next cycle.
  - In-flight slave beats are dropped; the slave is reset by the same rst.
- Unmapped response: m_r_valid or m_b_valid in IDLE/ADDR is not forwarded, and ready stays 0.

Optional Feature:
- Macro: AXI_ARB_PERF_EN.
- Defined:
  - Adds output ports perf_rd_grants and perf_wr_grants, each N*32.
  - Per-master 32-bit wrapping counters, incremented on each AR/AW handshake of that master.
  - Cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package axi_arb_pkg:
  - State encodings R_IDLE/R_ADDR/R_DATA and W_IDLE/W_ADDR/W_DATA/W_RESP.
  - AXI burst constants FIXED/INCR/WRAP.
  - Resp codes OKAY/EXOKAY/SLVERR/DECERR.
- One natural sub-module: axi_rr_pick.
  - Combinational round-robin picker: req[N], ptr -> gnt_idx, any_req.
  - Instantiated once per direction.

Test Plan:
- N=2; masters 0 and 1 raise ar_valid in the same cycle with rr_ptr=0 -> master 0 granted, m_ar_id=0; after its len=3 burst completes, master 1 is granted with m_ar_id=1 and rr_ptr=0 at the end.
- Master 1 issues a 4-beat read (data 0x11..0x44); master 0 requests mid-burst -> s_r_valid[0] stays 0 throughout; master 0 is granted the cycle after IDLE re-entry.
- Write from master 0, addr 0x80000000, len=1, strb 0xFF; slave delays aw_ready 3 cycles -> s_w_ready[0]=0 until the AW handshake; s_b_valid[0] pulses with resp=OKAY.
- N=4, all masters requesting continuously -> read grant order 0,1,2,3,0 with no starvation.
- rst asserted during beat 2 of an 8-beat read -> next cycle all valid/ready are 0 and rstate=R_IDLE; a fresh request is granted normally.
- AXI_ARB_PERF_EN defined, 3 reads from master 1 and 1 write from master 0 -> perf_rd_grants[1]=3 and perf_wr_grants[0]=1; all other counters 0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI round-robin arbiter.
// Optional build macro: AXI_ARB_PERF_EN (per-master grant counters).
package axi_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Next round-robin pointer after servicing index idx of n masters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter_if.sv
// Bundled upstream (flattened per-master) and downstream AXI4 signals of the arbiter.
// slave: the arbiter's view; master: the surrounding masters plus memory slave.
interface axi_rr_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned ID_WIDTH    = 4
);
    localparam int unsigned N      = NUM_MASTERS;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [N-1:0]            s_ar_valid;
    logic [N-1:0]            s_ar_ready;
    logic [N*ADDR_WIDTH-1:0] s_ar_addr;
    logic [N*8-1:0]          s_ar_len;
    logic [N*3-1:0]          s_ar_size;
    logic [N*2-1:0]          s_ar_burst;
    logic [N-1:0]            s_r_valid;
    logic [N-1:0]            s_r_ready;
    logic [DATA_WIDTH-1:0]   s_r_data;
    logic [1:0]              s_r_resp;
    logic                    s_r_last;
    logic [N-1:0]            s_aw_valid;
    logic [N-1:0]            s_aw_ready;
    logic [N*ADDR_WIDTH-1:0] s_aw_addr;
    logic [N*8-1:0]          s_aw_len;
    logic [N*3-1:0]          s_aw_size;
    logic [N*2-1:0]          s_aw_burst;
    logic [N-1:0]            s_w_valid;
    logic [N-1:0]            s_w_ready;
    logic [N*DATA_WIDTH-1:0] s_w_data;
    logic [N*STRB_W-1:0]     s_w_strb;
    logic [N-1:0]            s_w_last;
    logic [N-1:0]            s_b_valid;
    logic [N-1:0]            s_b_ready;
    logic [1:0]              s_b_resp;

    logic                    m_ar_valid;
    logic                    m_ar_ready;
    logic [ID_WIDTH-1:0]     m_ar_id;
    logic [ADDR_WIDTH-1:0]   m_ar_addr;
    logic [7:0]              m_ar_len;
    logic [2:0]              m_ar_size;
    logic [1:0]              m_ar_burst;
    logic                    m_r_valid;
    logic                    m_r_ready;
    logic [DATA_WIDTH-1:0]   m_r_data;
    logic [1:0]              m_r_resp;
    logic                    m_r_last;
    logic                    m_aw_valid;
    logic                    m_aw_ready;
    logic [ID_WIDTH-1:0]     m_aw_id;
    logic [ADDR_WIDTH-1:0]   m_aw_addr;
    logic [7:0]              m_aw_len;
    logic [2:0]              m_aw_size;
    logic [1:0]              m_aw_burst;
    logic                    m_w_valid;
    logic                    m_w_ready;
    logic [DATA_WIDTH-1:0]   m_w_data;
    logic [STRB_W-1:0]       m_w_strb;
    logic                    m_w_last;
    logic                    m_b_valid;
    logic                    m_b_ready;
    logic [1:0]              m_b_resp;

    modport slave (
        input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
        input  s_aw_valid, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst,
        input  s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready,
        output s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last,
        output s_aw_ready, s_w_ready, s_b_valid, s_b_resp,
        output m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
        output m_aw_valid, m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
        output m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
        input  m_aw_ready, m_w_ready, m_b_valid, m_b_resp
    );

    modport master (
        output s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
        output s_aw_valid, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst,
        output s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last,
        input  s_aw_ready, s_w_ready, s_b_valid, s_b_resp,
        input  m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
        input  m_aw_valid, m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
        input  m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
        output m_aw_ready, m_w_ready, m_b_valid, m_b_resp
    );

endinterface

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, modulo N.
module axi_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);
    int unsigned idx;
    logic        found;

    // Scan upward from ptr, keep the first hit.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt_idx = IDX_W'(idx);
                found   = 1'b1;
            end
        end
        any_req = found;
    end

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-to-1 AXI4 arbiter: independent round-robin read and write FSMs with burst-long grant hold.
// Optional build macro: AXI_ARB_PERF_EN adds per-master AR/AW grant counters.
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned ID_WIDTH    = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef AXI_ARB_PERF_EN
    output logic [NUM_MASTERS*32-1:0] perf_rd_grants,
    output logic [NUM_MASTERS*32-1:0] perf_wr_grants,
`endif
    axi_rr_arbiter_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    rd_state_e        r_state, r_state_nxt;
    logic [IDX_W-1:0] r_gnt, r_gnt_nxt, r_ptr, r_ptr_nxt, r_pick;
    logic             r_any;
    wr_state_e        w_state, w_state_nxt;
    logic [IDX_W-1:0] w_gnt, w_gnt_nxt, w_ptr, w_ptr_nxt, w_pick;
    logic             w_any;

    axi_rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rd_pick (
        .req(bus.s_ar_valid), .ptr(r_ptr), .gnt_idx(r_pick), .any_req(r_any)
    );

    axi_rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_wr_pick (
        .req(bus.s_aw_valid), .ptr(w_ptr), .gnt_idx(w_pick), .any_req(w_any)
    );

    // Read and write state, grant and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            w_state <= W_IDLE;
            w_gnt   <= '0;
            w_ptr   <= '0;
        end else begin
            r_state <= r_state_nxt;
            r_gnt   <= r_gnt_nxt;
            r_ptr   <= r_ptr_nxt;
            w_state <= w_state_nxt;
            w_gnt   <= w_gnt_nxt;
            w_ptr   <= w_ptr_nxt;
        end
    end

    // Read FSM: arbitrate, forward AR from the grant, route R beats back until last.
    always_comb begin
        r_state_nxt    = r_state;
        r_gnt_nxt      = r_gnt;
        r_ptr_nxt      = r_ptr;
        bus.s_ar_ready = '0;
        bus.s_r_valid  = '0;
        bus.m_ar_valid = 1'b0;
        bus.m_r_ready  = 1'b0;
        bus.m_ar_id    = ID_WIDTH'(r_gnt);
        bus.m_ar_addr  = bus.s_ar_addr[r_gnt*ADDR_WIDTH +: ADDR_WIDTH];
        bus.m_ar_len   = bus.s_ar_len[r_gnt*8 +: 8];
        bus.m_ar_size  = bus.s_ar_size[r_gnt*3 +: 3];
        bus.m_ar_burst = bus.s_ar_burst[r_gnt*2 +: 2];
        bus.s_r_data   = bus.m_r_data;
        bus.s_r_resp   = bus.m_r_resp;
        bus.s_r_last   = bus.m_r_last;
        case (r_state)
            R_IDLE: begin
                if (r_any) begin
                    r_gnt_nxt   = r_pick;
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                bus.m_ar_valid        = bus.s_ar_valid[r_gnt];
                bus.s_ar_ready[r_gnt] = bus.m_ar_ready;
                if (bus.s_ar_valid[r_gnt] && bus.m_ar_ready) begin
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                bus.s_r_valid[r_gnt] = bus.m_r_valid;
                bus.m_r_ready        = bus.s_r_ready[r_gnt];
                if (bus.m_r_valid && bus.s_r_ready[r_gnt] && bus.m_r_last) begin
                    r_state_nxt = R_IDLE;
                    r_ptr_nxt   = IDX_W'(rr_next(32'(r_gnt), NUM_MASTERS));
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Write FSM: arbitrate, forward AW, then W beats, then route B back to the grant.
    always_comb begin
        w_state_nxt    = w_state;
        w_gnt_nxt      = w_gnt;
        w_ptr_nxt      = w_ptr;
        bus.s_aw_ready = '0;
        bus.s_w_ready  = '0;
        bus.s_b_valid  = '0;
        bus.m_aw_valid = 1'b0;
        bus.m_w_valid  = 1'b0;
        bus.m_b_ready  = 1'b0;
        bus.m_aw_id    = ID_WIDTH'(w_gnt);
        bus.m_aw_addr  = bus.s_aw_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
        bus.m_aw_len   = bus.s_aw_len[w_gnt*8 +: 8];
        bus.m_aw_size  = bus.s_aw_size[w_gnt*3 +: 3];
        bus.m_aw_burst = bus.s_aw_burst[w_gnt*2 +: 2];
        bus.m_w_data   = bus.s_w_data[w_gnt*DATA_WIDTH +: DATA_WIDTH];
        bus.m_w_strb   = bus.s_w_strb[w_gnt*STRB_W +: STRB_W];
        bus.m_w_last   = bus.s_w_last[w_gnt];
        bus.s_b_resp   = bus.m_b_resp;
        case (w_state)
            W_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                bus.m_aw_valid        = bus.s_aw_valid[w_gnt];
                bus.s_aw_ready[w_gnt] = bus.m_aw_ready;
                if (bus.s_aw_valid[w_gnt] && bus.m_aw_ready) begin
                    w_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                bus.m_w_valid        = bus.s_w_valid[w_gnt];
                bus.s_w_ready[w_gnt] = bus.m_w_ready;
                if (bus.s_w_valid[w_gnt] && bus.m_w_ready && bus.s_w_last[w_gnt]) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bus.s_b_valid[w_gnt] = bus.m_b_valid;
                bus.m_b_ready        = bus.s_b_ready[w_gnt];
                if (bus.m_b_valid && bus.s_b_ready[w_gnt]) begin
                    w_state_nxt = W_IDLE;
                    w_ptr_nxt   = IDX_W'(rr_next(32'(w_gnt), NUM_MASTERS));
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

`ifdef AXI_ARB_PERF_EN
    logic rd_grant_hs;
    logic wr_grant_hs;

    assign rd_grant_hs = (r_state == R_ADDR) && bus.s_ar_valid[r_gnt] && bus.m_ar_ready;
    assign wr_grant_hs = (w_state == W_ADDR) && bus.s_aw_valid[w_gnt] && bus.m_aw_ready;

    // Per-master wrapping counters of address handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_grants <= '0;
            perf_wr_grants <= '0;
        end else begin
            if (rd_grant_hs) begin
                perf_rd_grants[r_gnt*32 +: 32] <= perf_rd_grants[r_gnt*32 +: 32] + 32'd1;
            end
            if (wr_grant_hs) begin
                perf_wr_grants[w_gnt*32 +: 32] <= perf_wr_grants[w_gnt*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Randomized self-checking bench for axi_rr_arbiter (4 masters) against a transaction-level model.
module tb_axi_rr_arbiter;
    import axi_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_rptr = 0;
    int   exp_wptr = 0;

    logic [AW-1:0] rd_addr  [N];
    logic [7:0]    rd_len   [N];
    logic [2:0]    rd_size  [N];
    logic [1:0]    rd_burst [N];
    logic [AW-1:0] wr_addr  [N];
    logic [7:0]    wr_len   [N];
    logic [7:0]    wr_strb  [N];
    logic [DW-1:0] wr_dat   [N][8];

    axi_rr_arbiter_if #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

`ifdef AXI_ARB_PERF_EN
    logic [N*32-1:0] perf_rd_grants;
    logic [N*32-1:0] perf_wr_grants;
    int exp_prd [N];
    int exp_pwr [N];
`endif

    axi_rr_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef AXI_ARB_PERF_EN
        .perf_rd_grants(perf_rd_grants),
        .perf_wr_grants(perf_wr_grants),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, want, $time);
        end
    endtask

    // Spec rule: first requesting master scanning upward from ptr, wrapping at N.
    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (p[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [1:0] rand_burst();
        case ($urandom_range(0, 2))
            0:       return BURST_FIXED;
            1:       return BURST_INCR;
            default: return BURST_WRAP;
        endcase
    endfunction

    task automatic rd_raise(input int m);
        rd_addr[m]  = $urandom;
        rd_len[m]   = 8'($urandom_range(0, 7));
        rd_size[m]  = 3'($urandom_range(0, 3));
        rd_burst[m] = rand_burst();
        bus.s_ar_addr[m*AW +: AW] = rd_addr[m];
        bus.s_ar_len[m*8 +: 8]    = rd_len[m];
        bus.s_ar_size[m*3 +: 3]   = rd_size[m];
        bus.s_ar_burst[m*2 +: 2]  = rd_burst[m];
        bus.s_ar_valid[m]         = 1'b1;
    endtask

    task automatic wr_raise(input int m);
        wr_addr[m] = $urandom;
        wr_len[m]  = 8'($urandom_range(0, 7));
        wr_strb[m] = 8'($urandom);
        for (int b = 0; b < 8; b++) wr_dat[m][b] = {$urandom, $urandom};
        bus.s_aw_addr[m*AW +: AW] = wr_addr[m];
        bus.s_aw_len[m*8 +: 8]    = wr_len[m];
        bus.s_aw_size[m*3 +: 3]   = 3'd3;
        bus.s_aw_burst[m*2 +: 2]  = BURST_INCR;
        bus.s_w_data[m*DW +: DW]  = wr_dat[m][0];
        bus.s_w_strb[m*8 +: 8]    = wr_strb[m];
        bus.s_w_last[m]           = (wr_len[m] == 8'd0);
        bus.s_w_valid[m]          = 1'b1;
        bus.s_aw_valid[m]         = 1'b1;
    endtask

    // Issue reads from every master in mask (more may join mid-burst) and follow them to completion.
    task automatic rd_round(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        logic [DW-1:0] data;
        logic [1:0]   resp;
        logic         hs;
        int           g, d, m;
        pend = mask;
        for (int i = 0; i < N; i++) if (mask[i]) rd_raise(i);
        while (pend != '0) begin
            g = pick(pend, exp_rptr);
            bus.m_r_valid = 1'b1;
            @(negedge clk);
            check("rd_idle_arvalid", 64'(bus.m_ar_valid), 64'd0);
            check("rd_idle_arready", 64'(bus.s_ar_ready), 64'd0);
            check("rd_idle_rvalid", 64'(bus.s_r_valid), 64'd0);
            check("rd_idle_rready", 64'(bus.m_r_ready), 64'd0);
            @(posedge clk); #1;
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
                bus.m_ar_ready = (k == d);
                bus.m_r_valid  = (k != d);
                @(negedge clk);
                check("rd_arvalid", 64'(bus.m_ar_valid), 64'd1);
                check("rd_arid", 64'(bus.m_ar_id), 64'(g));
                check("rd_araddr", 64'(bus.m_ar_addr), 64'(rd_addr[g]));
                check("rd_arlen", 64'(bus.m_ar_len), 64'(rd_len[g]));
                check("rd_arsizeburst", 64'({bus.m_ar_burst, bus.m_ar_size}), 64'({rd_burst[g], rd_size[g]}));
                check("rd_arready", 64'(bus.s_ar_ready), (k == d) ? (64'd1 << g) : 64'd0);
                check("rd_addr_rvalid", 64'(bus.s_r_valid), 64'd0);
                check("rd_addr_rready", 64'(bus.m_r_ready), 64'd0);
                @(posedge clk); #1;
            end
            bus.m_ar_ready    = 1'b0;
            bus.m_r_valid     = 1'b0;
            bus.s_ar_valid[g] = 1'b0;
            pend[g]           = 1'b0;
`ifdef AXI_ARB_PERF_EN
            exp_prd[g]++;
`endif
            for (int b = 0; b <= int'(rd_len[g]); b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    m = $urandom_range(0, N - 1);
                    if (!pend[m] && m != g) begin
                        rd_raise(m);
                        pend[m] = 1'b1;
                    end
                end
                d = $urandom_range(0, 2);
                repeat (d) begin
                    @(negedge clk);
                    check("rd_gap_rvalid", 64'(bus.s_r_valid), 64'd0);
                    check("rd_hold_arvalid", 64'(bus.m_ar_valid), 64'd0);
                    @(posedge clk); #1;
                end
                data = {$urandom, $urandom};
                resp = 2'($urandom);
                bus.m_r_data  = data;
                bus.m_r_resp  = resp;
                bus.m_r_last  = (b == int'(rd_len[g]));
                bus.m_r_valid = 1'b1;
                hs = 1'b0;
                for (int a = 0; !hs; a++) begin
                    bus.s_r_ready = N'($urandom);
                    if (a >= 2) bus.s_r_ready[g] = 1'b1;
                    @(negedge clk);
                    check("rd_rvalid", 64'(bus.s_r_valid), 64'd1 << g);
                    check("rd_rdata", 64'(bus.s_r_data), 64'(data));
                    check("rd_rresp_last", 64'({bus.s_r_resp, bus.s_r_last}), 64'({resp, b == int'(rd_len[g])}));
                    check("rd_rready", 64'(bus.m_r_ready), 64'(bus.s_r_ready[g]));
                    check("rd_hold_arvalid", 64'(bus.m_ar_valid), 64'd0);
                    hs = bus.s_r_ready[g];
                    @(posedge clk); #1;
                end
                bus.m_r_valid = 1'b0;
                bus.s_r_ready = '0;
            end
            exp_rptr = (g + 1) % N;
        end
    endtask

    // Issue writes from every master in mask; W data is offered before AW is accepted.
    task automatic wr_round(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        logic [1:0]   resp;
        logic         hs;
        int           g, d;
        pend = mask;
        for (int i = 0; i < N; i++) if (mask[i]) wr_raise(i);
        while (pend != '0) begin
            g = pick(pend, exp_wptr);
            bus.m_b_valid = 1'b1;
            bus.m_w_ready = 1'b1;
            @(negedge clk);
            check("wr_idle_awvalid", 64'(bus.m_aw_valid), 64'd0);
            check("wr_idle_awready", 64'(bus.s_aw_ready), 64'd0);
            check("wr_idle_wready", 64'(bus.s_w_ready), 64'd0);
            check("wr_idle_wvalid", 64'(bus.m_w_valid), 64'd0);
            check("wr_idle_bvalid", 64'(bus.s_b_valid), 64'd0);
            check("wr_idle_bready", 64'(bus.m_b_ready), 64'd0);
            @(posedge clk); #1;
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
                bus.m_aw_ready = (k == d);
                @(negedge clk);
                check("wr_awvalid", 64'(bus.m_aw_valid), 64'd1);
                check("wr_awid", 64'(bus.m_aw_id), 64'(g));
                check("wr_awaddr", 64'(bus.m_aw_addr), 64'(wr_addr[g]));
                check("wr_awlen", 64'(bus.m_aw_len), 64'(wr_len[g]));
                check("wr_awready", 64'(bus.s_aw_ready), (k == d) ? (64'd1 << g) : 64'd0);
                check("wr_early_wready", 64'(bus.s_w_ready), 64'd0);
                check("wr_early_wvalid", 64'(bus.m_w_valid), 64'd0);
                check("wr_addr_bvalid", 64'(bus.s_b_valid), 64'd0);
                @(posedge clk); #1;
            end
            bus.m_aw_ready    = 1'b0;
            bus.m_b_valid     = 1'b0;
            bus.s_aw_valid[g] = 1'b0;
            pend[g]           = 1'b0;
`ifdef AXI_ARB_PERF_EN
            exp_pwr[g]++;
`endif
            for (int b = 0; b <= int'(wr_len[g]); b++) begin
                hs = 1'b0;
                for (int a = 0; !hs; a++) begin
                    bus.m_w_ready = (a >= 2) ? 1'b1 : 1'($urandom);
                    @(negedge clk);
                    check("wr_wvalid", 64'(bus.m_w_valid), 64'd1);
                    check("wr_wdata", 64'(bus.m_w_data), 64'(wr_dat[g][b]));
                    check("wr_wstrb", 64'(bus.m_w_strb), 64'(wr_strb[g]));
                    check("wr_wlast", 64'(bus.m_w_last), 64'(b == int'(wr_len[g])));
                    check("wr_wready", 64'(bus.s_w_ready), bus.m_w_ready ? (64'd1 << g) : 64'd0);
                    check("wr_hold_awvalid", 64'(bus.m_aw_valid), 64'd0);
                    hs = bus.m_w_ready;
                    @(posedge clk); #1;
                end
                if (b < int'(wr_len[g])) begin
                    bus.s_w_data[g*DW +: DW] = wr_dat[g][b+1];
                    bus.s_w_last[g]          = (b + 1 == int'(wr_len[g]));
                end
            end
            bus.s_w_valid[g] = 1'b0;
            bus.m_w_ready    = 1'b0;
            d = $urandom_range(0, 2);
            repeat (d) begin
                @(negedge clk);
                check("wr_gap_bvalid", 64'(bus.s_b_valid), 64'd0);
                check("wr_resp_wvalid", 64'(bus.m_w_valid), 64'd0);
                @(posedge clk); #1;
            end
            resp = 2'($urandom);
            bus.m_b_resp  = resp;
            bus.m_b_valid = 1'b1;
            hs = 1'b0;
            for (int a = 0; !hs; a++) begin
                bus.s_b_ready = N'($urandom);
                if (a >= 2) bus.s_b_ready[g] = 1'b1;
                @(negedge clk);
                check("wr_bvalid", 64'(bus.s_b_valid), 64'd1 << g);
                check("wr_bresp", 64'(bus.s_b_resp), 64'(resp));
                check("wr_bready", 64'(bus.m_b_ready), 64'(bus.s_b_ready[g]));
                hs = bus.s_b_ready[g];
                @(posedge clk); #1;
            end
            bus.m_b_valid = 1'b0;
            bus.s_b_ready = '0;
            exp_wptr = (g + 1) % N;
        end
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_arv_arr"}, 64'({bus.m_ar_valid, bus.s_ar_ready}), 64'd0);
        check({tag, "_rv_rr"}, 64'({bus.s_r_valid, bus.m_r_ready}), 64'd0);
        check({tag, "_awv_awr"}, 64'({bus.m_aw_valid, bus.s_aw_ready}), 64'd0);
        check({tag, "_wv_wr"}, 64'({bus.m_w_valid, bus.s_w_ready}), 64'd0);
        check({tag, "_bv_br"}, 64'({bus.s_b_valid, bus.m_b_ready}), 64'd0);
    endtask

    initial begin
        logic [N-1:0] rm, wm;
        rst = 1'b1;
        bus.s_ar_valid = '0; bus.s_ar_addr = '0; bus.s_ar_len = '0; bus.s_ar_size = '0; bus.s_ar_burst = '0;
        bus.s_r_ready  = '0;
        bus.s_aw_valid = '0; bus.s_aw_addr = '0; bus.s_aw_len = '0; bus.s_aw_size = '0; bus.s_aw_burst = '0;
        bus.s_w_valid  = '0; bus.s_w_data = '0; bus.s_w_strb = '0; bus.s_w_last = '0;
        bus.s_b_ready  = '0;
        bus.m_ar_ready = 1'b0; bus.m_r_valid = 1'b0; bus.m_r_data = '0; bus.m_r_resp = RESP_OKAY; bus.m_r_last = 1'b0;
        bus.m_aw_ready = 1'b0; bus.m_w_ready = 1'b0; bus.m_b_valid = 1'b0; bus.m_b_resp = RESP_OKAY;
`ifdef AXI_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin exp_prd[i] = 0; exp_pwr[i] = 0; end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        rd_round(4'b0011);
        rd_round(4'b1111);
        wr_round(4'b0001);
        fork
            rd_round(4'b0110);
            wr_round(4'b0110);
        join
        for (int it = 0; it < 40; it++) begin
            rm = N'($urandom_range(1, 15));
            wm = N'($urandom_range(1, 15));
            fork
                rd_round(rm);
                wr_round(wm);
            join
        end

        // Reset in the middle of an 8-beat read from master 2.
        rd_raise(2);
        rd_len[2] = 8'd7;
        bus.s_ar_len[2*8 +: 8] = 8'd7;
        bus.m_ar_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_arid", 64'({bus.m_ar_valid, bus.m_ar_id}), 64'({1'b1, 4'd2}));
        @(posedge clk); #1;
        bus.m_ar_ready = 1'b0;
        bus.s_ar_valid[2] = 1'b0;
        bus.s_r_ready = '1;
        bus.m_r_valid = 1'b1;
        bus.m_r_last  = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        bus.m_b_valid = 1'b1;
        @(negedge clk);
        check("rst_pre_rvalid", 64'(bus.s_r_valid), 64'd4);
        @(posedge clk); #1;
        @(negedge clk);
        check_all_quiet("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        bus.m_r_valid = 1'b0;
        bus.m_b_valid = 1'b0;
        bus.s_r_ready = '0;
        exp_rptr = 0;
        exp_wptr = 0;
`ifdef AXI_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin exp_prd[i] = 0; exp_pwr[i] = 0; end
`endif
        fork
            rd_round(4'b1111);
            wr_round(4'b1110);
        join
        rd_round(4'b0010);
        rd_round(4'b0010);

`ifdef AXI_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin
            check("perf_rd", 64'(perf_rd_grants[i*32 +: 32]), 64'(exp_prd[i]));
            check("perf_wr", 64'(perf_wr_grants[i*32 +: 32]), 64'(exp_pwr[i]));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
